// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Multi-read register file with write-through bypass and a per-register
//   pending-write scoreboard. It sits at the decode/write-back boundary.
//   - Decode reads operands and hazard flags combinationally.
//   - Issue reserves destination registers.
//   - Write-back commits data and releases the reservation.
//
// Parameters
//   DATA_W    register width
//   ADDR_W    address width, depth = 2**ADDR_W
//   ZERO_REG  1: register 0 reads 0, drops writes and is never busy
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   rd_addr{1,2}_i             read addresses
//   rd_data{1,2}_o             read data (combinational, bypassed)
//   rd_busy{1,2}_o             pending-write flag (combinational, bypassed)
//   wr_en_i/wr_addr_i/wr_data_i  write-back commit
//   rsv_en_i/rsv_addr_i        destination reservation request
//   rsv_ok_o                   reservation accepted this cycle
//   flush_i                    drop all reservations
//   pend_cnt_o                 registered count of busy registers
// ---------------------------------------------------------------------------

// Per-read-port mux: zero-register override, then write bypass, then the
// stored word.
module regfile_sb_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] stored_data_i,
  input  logic              stored_busy_i,
  input  logic              wr_eff_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);
  always_comb begin
    data_o = stored_data_i;
    busy_o = stored_busy_i;
    if ((ZERO_REG != 0) && (addr_i == '0)) begin
      data_o = '0;
      busy_o = 1'b0;
    end else if (wr_eff_i && (wr_addr_i == addr_i)) begin
      // The committing write both supplies the data and retires the hazard.
      data_o = wr_data_i;
      busy_o = 1'b0;
    end
  end
endmodule

module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
  output logic              rd_busy1_o,
  output logic              rd_busy2_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic              rsv_ok_o,
  input  logic              flush_i,
  output logic [ADDR_W:0]   pend_cnt_o
);
  localparam int  DEPTH    = 1 << ADDR_W;
  localparam int  NUM_RD   = 2;
  localparam int  CNT_W    = ADDR_W + 1;
  localparam bit  HAS_ZERO = (ZERO_REG != 0);

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;

  wr_req_t wr;
  logic    rsv_zero;
  logic    rsv_set;
  logic    cnt_inc, cnt_dec;

  // Writes to a hardwired-zero register are dropped entirely, which also
  // keeps them out of the bypass path.
  always_comb begin
    wr.en   = wr_en_i & ~(HAS_ZERO & (wr_addr_i == '0));
    wr.addr = wr_addr_i;
    wr.data = wr_data_i;
  end

  assign rsv_zero = HAS_ZERO & (rsv_addr_i == '0);

  // A busy register is still grantable when its producer commits this cycle.
  assign rsv_ok_o = rsv_en_i &
                    (rsv_zero | ~busy_q[rsv_addr_i] |
                     (wr.en & (wr.addr == rsv_addr_i)));

  // Flush discards the grant's effect; register 0 never takes a busy bit.
  assign rsv_set = rsv_ok_o & ~flush_i & ~rsv_zero;

  // ---------------- read ports ----------------
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_busy;

  assign rd_addr = {rd_addr2_i, rd_addr1_i};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .addr_i       (rd_addr[g]),
      .stored_data_i(mem_q[rd_addr[g]]),
      .stored_busy_i(busy_q[rd_addr[g]]),
      .wr_eff_i     (wr.en),
      .wr_addr_i    (wr.addr),
      .wr_data_i    (wr.data),
      .data_o       (rd_data[g]),
      .busy_o       (rd_busy[g])
    );
  end

  assign rd_data1_o = rd_data[0];
  assign rd_data2_o = rd_data[1];
  assign rd_busy1_o = rd_busy[0];
  assign rd_busy2_o = rd_busy[1];

  // ---------------- scoreboard next state ----------------
  // Reservation is applied after the write clear so that a same-address
  // write + grant leaves the bit set for the new producer.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wr.en)   busy_d[wr.addr]    = 1'b0;
      if (rsv_set) busy_d[rsv_addr_i] = 1'b1;
    end
  end

  // Incremental popcount: +1 for a 0->1 bit, -1 for a 1->0 bit. A write
  // that clears a bit being re-reserved is a net no-change.
  assign cnt_inc = rsv_set & ~busy_q[rsv_addr_i];
  assign cnt_dec = wr.en & busy_q[wr.addr] &
                   ~(rsv_set & (rsv_addr_i == wr.addr));

  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (flush_i) pend_cnt_d = '0;
    else         pend_cnt_d = pend_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr.en) begin
      mem_q[wr.addr] <= wr.data;
    end
  end

  assign pend_cnt_o = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_busy1, rd_busy2;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rsv_en = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic          rsv_ok;
  logic          flush = 1'b0;
  logic [AW:0]   pend_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
    .rd_data1_o(rd_data1), .rd_data2_o(rd_data2),
    .rd_busy1_o(rd_busy1), .rd_busy2_o(rd_busy2),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .rsv_ok_o(rsv_ok),
    .flush_i(flush), .pend_cnt_o(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem  [N];
  bit            m_busy [N];

  function automatic logic [DW-1:0] m_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic m_bsy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic m_rok();
    if (!rsv_en) return 1'b0;
    if (rsv_addr == 0) return 1'b1;
    return !m_busy[rsv_addr] || (wr_en && wr_addr == rsv_addr);
  endfunction

  function automatic int m_pop();
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    end else begin
      logic ok;
      ok = m_rok();
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (ok && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      if (flush) for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_rd_data1", rd_data1, m_data(rd_addr1));
      chk("cmp_rd_data2", rd_data2, m_data(rd_addr2));
      chk("cmp_rd_busy1", 32'(rd_busy1), 32'(m_bsy(rd_addr1)));
      chk("cmp_rd_busy2", 32'(rd_busy2), 32'(m_bsy(rd_addr2)));
      chk("cmp_rsv_ok", 32'(rsv_ok), 32'(m_rok()));
      chk("cmp_pend_cnt", 32'(pend_cnt), 32'(m_pop()));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic do_rsv(input logic [AW-1:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    // reset for two cycles
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // every address reads zero and idle after reset
    for (int i = 0; i < N; i++) begin
      cyc(); rd_addr1 = AW'(i); rd_addr2 = AW'(N - 1 - i); #1;
      chk("rst_rd1", rd_data1, 32'h0);
      chk("rst_rd2", rd_data2, 32'h0);
      chk("rst_busy1", 32'(rd_busy1), 32'h0);
      chk("rst_pend", 32'(pend_cnt), 32'h0);
    end

    // write with same-cycle bypass, then stored value
    cyc(); do_wr(5, 32'hDEADBEEF); rd_addr1 = 5; #1;
    chk("byp_rd1", rd_data1, 32'hDEADBEEF);
    chk("byp_busy1", 32'(rd_busy1), 32'h0);
    cyc(); idle(); #1;
    chk("stored_rd1", rd_data1, 32'hDEADBEEF);

    // hardwired zero register
    cyc(); do_wr(0, 32'h1234); do_rsv(0); rd_addr1 = 0; rd_addr2 = 0; #1;
    chk("zero_rd1", rd_data1, 32'h0);
    chk("zero_busy1", 32'(rd_busy1), 32'h0);
    chk("zero_rsv_ok", 32'(rsv_ok), 32'h1);
    cyc(); idle(); #1;
    chk("zero_rd_after", rd_data2, 32'h0);
    chk("zero_pend", 32'(pend_cnt), 32'h0);

    // scoreboard on register 7
    cyc(); do_rsv(7); rd_addr1 = 7; #1;
    chk("r7_ok", 32'(rsv_ok), 32'h1);
    chk("r7_busy_same_cycle", 32'(rd_busy1), 32'h0);
    cyc(); #1;
    chk("r7_busy", 32'(rd_busy1), 32'h1);
    chk("r7_pend", 32'(pend_cnt), 32'h1);
    chk("r7_refused", 32'(rsv_ok), 32'h0);
    cyc(); idle(); do_wr(7, 32'hAA); #1;
    chk("r7_wr_busy", 32'(rd_busy1), 32'h0);
    chk("r7_wr_data", rd_data1, 32'hAA);
    cyc(); idle(); #1;
    chk("r7_free_busy", 32'(rd_busy1), 32'h0);
    chk("r7_free_pend", 32'(pend_cnt), 32'h0);

    // write + re-reserve of busy register 9
    cyc(); do_rsv(9); rd_addr1 = 9; #1;
    chk("r9_ok", 32'(rsv_ok), 32'h1);
    cyc(); do_wr(9, 32'h99); #1;
    chk("r9_rerez_ok", 32'(rsv_ok), 32'h1);
    chk("r9_pend_before", 32'(pend_cnt), 32'h1);
    cyc(); idle(); #1;
    chk("r9_data", rd_data1, 32'h99);
    chk("r9_busy", 32'(rd_busy1), 32'h1);
    chk("r9_pend", 32'(pend_cnt), 32'h1);
    cyc(); do_wr(9, 32'h100); #1;
    cyc(); idle(); #1;
    chk("r9_rel_pend", 32'(pend_cnt), 32'h0);
    chk("r9_rel_data", rd_data1, 32'h100);

    // flush with same-cycle write and reservation
    cyc(); do_rsv(3);
    cyc(); do_rsv(4);
    cyc(); do_rsv(6);
    cyc(); idle(); rd_addr1 = 4; #1;
    chk("fl_pend3", 32'(pend_cnt), 32'h3);
    chk("fl_busy4", 32'(rd_busy1), 32'h1);
    cyc(); flush = 1'b1; do_wr(4, 32'h44); do_rsv(10); rd_addr2 = 10; #1;
    chk("fl_rsv_ok", 32'(rsv_ok), 32'h1);
    cyc(); idle(); #1;
    chk("fl_pend0", 32'(pend_cnt), 32'h0);
    chk("fl_busy4_clr", 32'(rd_busy1), 32'h0);
    chk("fl_data4", rd_data1, 32'h44);
    chk("fl_busy10", 32'(rd_busy2), 32'h0);
    rd_addr1 = 3; #1 chk("fl_busy3", 32'(rd_busy1), 32'h0);
    rd_addr1 = 6; #1 chk("fl_busy6", 32'(rd_busy1), 32'h0);

    // asynchronous reset between edges
    cyc(); do_rsv(12); rd_addr1 = 4; rd_addr2 = 12;
    cyc(); idle(); #1;
    chk("ar_pend1", 32'(pend_cnt), 32'h1);
    chk("ar_busy12", 32'(rd_busy2), 32'h1);
    rst_n = 1'b0; #1;
    chk("ar_rd1", rd_data1, 32'h0);
    chk("ar_busy12_clr", 32'(rd_busy2), 32'h0);
    chk("ar_pend0", 32'(pend_cnt), 32'h0);
    cyc(); cyc(); rst_n = 1'b1;
    cyc(); #1;
    chk("ar_post_rd1", rd_data1, 32'h0);
    chk("ar_post_pend", 32'(pend_cnt), 32'h0);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
